mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
//
// PURPOSE
// Shares the single-port synchronous program/data RAM between two requesters:
// port 0 is the CPU core and port 1 is the loader/debug master. It arbitrates
// with a req/gnt handshake, drives the RAM address, data and wren lines from
// registers, and returns read data with a one-cycle valid strobe to the owner.
// It sits between the requesters and the RAM. Issue rate is one access per 2 cycles.
//
// PARAMETERS
// ADDR_W      16  RAM word-address width
// DATA_W      32  RAM data width
// FIXED_PRIO  0   0 = round-robin; 1 = port 0 always wins ties (port 1 may starve)
//
// PORTS
// clk          in   1       system clock, all state on posedge
// rst_n        in   1       asynchronous, active-low reset
// req0/req1    in   1       access request; held, with fields stable, until gnt
// we0/we1      in   1       1 = write, 0 = read
// addr0/addr1  in   ADDR_W  word address
// wdata0/1     in   DATA_W  write data
// gnt0/gnt1    out  1       1-cycle pulse: access issued to RAM this cycle
// rvalid0/1    out  1       1-cycle pulse: rdata holds this port's read result
// rdata        out  DATA_W  combinational pass-through of mem_q
// mem_address  out  ADDR_W  RAM address (registered)
// mem_data     out  DATA_W  RAM write data (registered)
// mem_wren     out  1       RAM write enable (registered)
// mem_q        in   DATA_W  RAM read data, valid 1 cycle after address is presented
// status       out  8       {5'b0, busy, last_winner, pending_both}
//
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, gnt*=0, rvalid*=0, mem_wren=0,
//   mem_address=0, mem_data=0, last_winner=1 (port 0 wins the first tie).
// - FSM: IDLE, BUSY.
//   IDLE: if any req is high at the edge, select winner, register
//     mem_address/mem_data/mem_wren from it, set its gnt, set last_winner,
//     go to BUSY. Otherwise mem_wren<=0 and stay in IDLE.
//   BUSY: gnt*<=0, mem_wren<=0, mem_address holds, always return to IDLE.
//   The request is consumed in the cycle gnt is high. A req still high in the
//   following IDLE cycle is a new request.
// - Winner: only one req -> that port. Both: FIXED_PRIO=1 -> port 0; else the
//   port that is not last_winner.
// - Read latency: gnt high in cycle N (address on RAM), rvalid high in cycle N+1,
//   rdata=mem_q in that cycle. rvalid_i <= gnt_i & ~we_i registered in BUSY.
//   Writes produce no rvalid. mem_wren is high only in the gnt cycle.
// - The rvalid of access k may coincide with the gnt of access k+1. Both are legal.
// - gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together.
// - Requests dropped before gnt are ignored and leave no state. A req change
//   during BUSY has no effect until IDLE.
// - Reset mid-access: all outputs clear immediately. The in-flight read never
//   produces rvalid after release. mem_wren=0 protects RAM from a partial write.
// - status[2]=busy (state==BUSY), [1]=last_winner, [0]=req0&req1 this cycle.
//
// TESTING
// 1. RAM[0x0010]=0xDEADBEEF; req0 read 0x0010 at cycle 0 -> cycle 1 gnt0=1,
//    mem_address=0x0010, mem_wren=0. Cycle 2: rvalid0=1, rdata=0xDEADBEEF.
// 2. After reset, req0 and req1 both rise together -> gnt0 first (cycle 1).
//    gnt1 follows in cycle 3.
// 3. req0 and req1 held high for 12 cycles, round-robin -> grants alternate
//    0,1,0,1,... every 2 cycles. No cycle ever has both gnt high.
// 4. Port 1 writes 0x12345678 to 0x00FF (mem_wren=1 for exactly 1 cycle), then
//    port 0 reads 0x00FF -> rvalid0 with rdata=0x12345678. rvalid1 is never asserted.
// 5. Port 0 read granted; rst_n pulled low in the following cycle -> gnt0,
//    rvalid0 and mem_wren go low immediately. No rvalid0 occurs after rst_n=1.
// 6. FIXED_PRIO=1, req0 and req1 both held -> only gnt0 pulses. When req0 drops,
//    the next IDLE edge grants port 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for the two-port RAM arbiter: per-port request fields,
// grant/read-valid strobes and the shared read-data return.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM (port 0 = CPU,
// port 1 = loader/debug). One access issued every two cycles, reads return one cycle later.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] memAddress_o,
  output logic [DATA_W-1:0] memData_o,
  output logic              memWren_o,
  input  logic [DATA_W-1:0] memQ_i,
  output logic [7:0]        status_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit FixedPrio = (FIXED_PRIO != 0);

  state_t            state_q, state_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              memWren_q, memWren_d;
  logic [ADDR_W-1:0] memAddress_q, memAddress_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  logic              lastWinner_q, lastWinner_d;

  logic anyReq;
  logic pick1;

  // lastWinner_q=1 means port 1 won last, so port 0 takes the next tie.
  assign anyReq = bus.req0 | bus.req1;
  assign pick1  = bus.req1 & ~(bus.req0 & (FixedPrio | lastWinner_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      memWren_q    <= 1'b0;
      memAddress_q <= '0;
      memData_q    <= '0;
      lastWinner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      memWren_q    <= memWren_d;
      memAddress_q <= memAddress_d;
      memData_q    <= memData_d;
      lastWinner_q <= lastWinner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = BUSY;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write enable of the granted access tells BUSY whether a read is in flight.
  always_comb begin
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    memWren_d    = 1'b0;
    memAddress_d = memAddress_q;
    memData_d    = memData_q;
    lastWinner_d = lastWinner_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          gnt0_d       = ~pick1;
          gnt1_d       = pick1;
          memWren_d    = pick1 ? bus.we1 : bus.we0;
          memAddress_d = pick1 ? bus.addr1 : bus.addr0;
          memData_d    = pick1 ? bus.wdata1 : bus.wdata0;
          lastWinner_d = pick1;
        end
      end
      BUSY: begin
        rvalid0_d = gnt0_q & ~memWren_q;
        rvalid1_d = gnt1_q & ~memWren_q;
      end
      default: ;
    endcase
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata    = memQ_i;
  assign memAddress_o = memAddress_q;
  assign memData_o    = memData_q;
  assign memWren_o    = memWren_q;
  assign status_o     = {5'b0, (state_q == BUSY), lastWinner_q, bus.req0 & bus.req1};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a small RAM model
// and a fixed-priority instance for the starvation case.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) busA ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) busB ();

  logic [15:0] memAddressA, memAddressB;
  logic [31:0] memDataA, memDataB;
  logic        memWrenA, memWrenB;
  logic [31:0] memQA, memQB;
  logic [7:0]  statusA, statusB;
  logic [31:0] ramA [256];

  int checkCount;
  int errorCount;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .FIXED_PRIO(0)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA),
    .memAddress_o(memAddressA), .memData_o(memDataA), .memWren_o(memWrenA),
    .memQ_i(memQA), .status_o(statusA)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .FIXED_PRIO(1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB),
    .memAddress_o(memAddressB), .memData_o(memDataB), .memWren_o(memWrenB),
    .memQ_i(memQB), .status_o(statusB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the address; preloaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      ramA[8'h10] <= 32'hDEADBEEF;
      ramA[8'h20] <= 32'hA0A0A0A0;
      ramA[8'h21] <= 32'hB1B1B1B1;
    end else if (memWrenA) begin
      ramA[memAddressA[7:0]] <= memDataA;
    end
    memQA <= ramA[memAddressA[7:0]];
  end

  always @(posedge clk) memQB <= {memDataB[15:0], memAddressB};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [15:0] a1, input logic [31:0] d1);
    busA.req0 = r0; busA.we0 = w0; busA.addr0 = a0; busA.wdata0 = d0;
    busA.req1 = r1; busA.we1 = w1; busA.addr1 = a1; busA.wdata1 = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    applyStimulus(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
    busB.req0 = 0; busB.we0 = 0; busB.addr0 = 16'h0030; busB.wdata0 = 32'h0;
    busB.req1 = 0; busB.we1 = 0; busB.addr1 = 16'h0031; busB.wdata1 = 32'h0;
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_gnt0", {31'b0, busA.gnt0}, 32'd0);
    checkOutput("rst_gnt1", {31'b0, busA.gnt1}, 32'd0);
    checkOutput("rst_rvalid", {30'b0, busA.rvalid1, busA.rvalid0}, 32'd0);
    checkOutput("rst_wren", {31'b0, memWrenA}, 32'd0);
    checkOutput("rst_addr", {16'b0, memAddressA}, 32'h0);
    checkOutput("rst_data", memDataA, 32'h0);
    checkOutput("rst_status", {24'b0, statusA}, 32'h02);
    rst_n = 1'b1;

    // Single port-0 read
    applyStimulus(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    tick();
    checkOutput("t1_gnt0", {31'b0, busA.gnt0}, 32'd1);
    checkOutput("t1_gnt1", {31'b0, busA.gnt1}, 32'd0);
    checkOutput("t1_addr", {16'b0, memAddressA}, 32'h0010);
    checkOutput("t1_wren", {31'b0, memWrenA}, 32'd0);
    checkOutput("t1_status", {24'b0, statusA}, 32'h04);
    busA.req0 = 0;
    tick();
    checkOutput("t1_rvalid0", {31'b0, busA.rvalid0}, 32'd1);
    checkOutput("t1_rdata", busA.rdata, 32'hDEADBEEF);
    checkOutput("t1_gnt0_off", {31'b0, busA.gnt0}, 32'd0);
    checkOutput("t1_status2", {24'b0, statusA}, 32'h00);
    tick();
    checkOutput("t1_rvalid0_off", {31'b0, busA.rvalid0}, 32'd0);

    // Both ports held after reset: port 0 first, then strict alternation
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 16'h0020, 32'h0, 1, 0, 16'h0021, 32'h0);
    #1;
    checkOutput("t2_pending", {24'b0, statusA}, 32'h03);
    for (int c = 1; c <= 12; c++) begin
      tick();
      checkOutput($sformatf("t3_gnt0_c%0d", c), {31'b0, busA.gnt0}, {31'b0, (c % 4) == 1});
      checkOutput($sformatf("t3_gnt1_c%0d", c), {31'b0, busA.gnt1}, {31'b0, (c % 4) == 3});
      checkOutput($sformatf("t3_rv0_c%0d", c), {31'b0, busA.rvalid0}, {31'b0, (c % 4) == 2});
      checkOutput($sformatf("t3_rv1_c%0d", c), {31'b0, busA.rvalid1}, {31'b0, (c % 4) == 0});
      if ((c % 4) == 2) checkOutput($sformatf("t3_rd0_c%0d", c), busA.rdata, 32'hA0A0A0A0);
      if ((c % 4) == 0) checkOutput($sformatf("t3_rd1_c%0d", c), busA.rdata, 32'hB1B1B1B1);
    end

    // Port 1 writes, port 0 reads it back; a req pulse during BUSY is ignored
    applyStimulus(0, 0, 16'h0, 32'h0, 1, 1, 16'h00FF, 32'h12345678);
    tick();
    checkOutput("t4_gnt1", {31'b0, busA.gnt1}, 32'd1);
    checkOutput("t4_wren", {31'b0, memWrenA}, 32'd1);
    checkOutput("t4_addr", {16'b0, memAddressA}, 32'h00FF);
    checkOutput("t4_data", memDataA, 32'h12345678);
    checkOutput("t4_status", {24'b0, statusA}, 32'h06);
    busA.req1 = 0;
    tick();
    checkOutput("t4_wren_off", {31'b0, memWrenA}, 32'd0);
    checkOutput("t4_no_rv1", {31'b0, busA.rvalid1}, 32'd0);
    applyStimulus(1, 0, 16'h00FF, 32'h0, 0, 0, 16'h0, 32'h0);
    tick();
    checkOutput("t4_gnt0", {31'b0, busA.gnt0}, 32'd1);
    checkOutput("t4_rd_wren", {31'b0, memWrenA}, 32'd0);
    applyStimulus(0, 0, 16'h0, 32'h0, 1, 0, 16'h0021, 32'h0);
    tick();
    checkOutput("t4_rvalid0", {31'b0, busA.rvalid0}, 32'd1);
    checkOutput("t4_rdata", busA.rdata, 32'h12345678);
    checkOutput("t4_rv1_idle", {31'b0, busA.rvalid1}, 32'd0);
    checkOutput("t4_busy_req", {31'b0, busA.gnt1}, 32'd0);
    busA.req1 = 0;
    tick();
    checkOutput("t4_drop_gnt", {30'b0, busA.gnt1, busA.gnt0}, 32'd0);
    checkOutput("t4_status2", {24'b0, statusA}, 32'h00);

    // Reset in the cycle after a read grant
    applyStimulus(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    tick();
    checkOutput("t5_gnt0", {31'b0, busA.gnt0}, 32'd1);
    busA.req0 = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_gnt0", {31'b0, busA.gnt0}, 32'd0);
    checkOutput("t5_rst_wren", {31'b0, memWrenA}, 32'd0);
    checkOutput("t5_rst_rv0", {31'b0, busA.rvalid0}, 32'd0);
    checkOutput("t5_rst_status", {24'b0, statusA}, 32'h02);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput($sformatf("t5_no_rv0_c%0d", c), {31'b0, busA.rvalid0}, 32'd0);
    end

    // Fixed priority: port 1 starves until port 0 lets go
    busB.req0 = 1;
    busB.req1 = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("t6_gnt0_c%0d", c), {31'b0, busB.gnt0}, {31'b0, (c % 2) == 1});
      checkOutput($sformatf("t6_gnt1_c%0d", c), {31'b0, busB.gnt1}, 32'd0);
    end
    busB.req0 = 0;
    tick();
    checkOutput("t6_gnt1", {31'b0, busB.gnt1}, 32'd1);
    checkOutput("t6_gnt0_off", {31'b0, busB.gnt0}, 32'd0);
    checkOutput("t6_addr", {16'b0, memAddressB}, 32'h0031);
    busB.req1 = 0;
    tick();
    checkOutput("t6_rvalid1", {31'b0, busB.rvalid1}, 32'd1);
    checkOutput("t6_rdata", busB.rdata, 32'h00000031);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Grant and read-valid strobes must be one-hot per instance at every sample point.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busA.gnt0 && busA.gnt1) checkOutput("excl_gntA", 32'd1, 32'd0);
      if (busA.rvalid0 && busA.rvalid1) checkOutput("excl_rvA", 32'd1, 32'd0);
      if (busB.gnt0 && busB.gnt1) checkOutput("excl_gntB", 32'd1, 32'd0);
    end
  end

endmodule
